// File: rtl/pergate_compute_fj_acc_pkg.sv
// Shared types, state encoding and GF(p) modular add for the per-gate F_j accumulator.
// Field width and modulus come from F_NBITS / F_PRIME (default p = 2^61-1).
`ifndef F_NBITS
`define F_NBITS 61
`endif
`ifndef F_PRIME
`define F_PRIME 61'h1FFF_FFFF_FFFF_FFFF
`endif

package pergate_fj_pkg;
  localparam int F_NBITS = `F_NBITS;

  typedef logic [F_NBITS-1:0] fe_t;

  localparam fe_t FIELD_P = `F_PRIME;

  typedef enum logic [2:0] {IDLE, RUN, MUL, ACC, DONE} state_e;

  // Sequencing of the single time-multiplexed multiplier in the shared build
  typedef enum logic [1:0] {PH_ISSUE, PH_WAIT, PH_STORE} phase_e;

  function automatic fe_t fe_add_mod(fe_t a, fe_t b);
    logic [F_NBITS:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, FIELD_P}) s = s - {1'b0, FIELD_P};
    return s[F_NBITS-1:0];
  endfunction
endpackage

// File: rtl/field_multiplier.sv
// GF(p) multiplier with en/ready handshake: en captures operands; ready and prod_o
// are valid LAT cycles later counting the en cycle (LAT >= 2). Operands held until next en.
module field_multiplier
  import pergate_fj_pkg::*;
#(
  parameter int LAT = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  fe_t  a_i,
  input  fe_t  b_i,
  output logic ready_o,
  output fe_t  prod_o
);
  localparam int CW = $clog2(LAT + 1);

  fe_t             a_q, b_q;
  logic [CW-1:0]   cnt_q;
  logic [2*F_NBITS-1:0] full;
  logic [2*F_NBITS-1:0] red;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_q   <= '0;
      b_q   <= '0;
      cnt_q <= '0;
    end else if (en_i) begin
      a_q   <= a_i;
      b_q   <= b_i;
      cnt_q <= CW'(LAT - 2);
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign full    = {{F_NBITS{1'b0}}, a_q} * {{F_NBITS{1'b0}}, b_q};
  assign red     = full % {{F_NBITS{1'b0}}, FIELD_P};
  assign prod_o  = red[F_NBITS-1:0];
  // Low in the en cycle so a caller never mistakes the previous result for the new one
  assign ready_o = (cnt_q == '0) && !en_i;
endmodule

// File: rtl/pergate_compute_fj_acc_add.sv
// Combinational GF(p) adder: one instance per evaluation point in the accumulator.
module field_add_mod
  import pergate_fj_pkg::*;
(
  input  fe_t a_i,
  input  fe_t b_i,
  output fe_t sum_o
);
  assign sum_o = fe_add_mod(a_i, b_i);
endmodule

// File: rtl/pergate_compute_fj_acc.sv
// Streaming per-gate F_j accumulator: sum over a batch of gatefn[k]*addmul[k] mod p, k < NPTS.
// COMPUTE_FJ_SHARED_MUL_EN: one multiplier shared over the points instead of NPTS in parallel.
//
// state | meaning
// IDLE  | after reset, waiting for start
// RUN   | accepting one gate
// MUL   | products in flight
// ACC   | out[k] += prod[k] mod p
// DONE  | batch sums final, held until next start
module pergate_compute_fj_acc
  import pergate_fj_pkg::*;
#(
  parameter int NPTS    = 3,
  parameter int MUL_LAT = 2
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           start_i,
  input  logic                           in_valid_i,
  output logic                           in_ready_o,
  input  logic                           in_last_i,
  input  logic [NPTS-1:0][F_NBITS-1:0]   gatefn_i,
  input  logic [NPTS-1:0][F_NBITS-1:0]   addmul_i,
  output logic                           out_valid_o,
  output logic                           done_o,
  output logic [NPTS-1:0][F_NBITS-1:0]   out_o
);
  state_e state_q, state_d;

  logic [NPTS-1:0][F_NBITS-1:0] gf_q, am_q;
  logic [NPTS-1:0][F_NBITS-1:0] out_q, out_d;
  logic [NPTS-1:0][F_NBITS-1:0] prod, sum;
  logic last_q;
  logic out_valid_q, out_valid_d;
  logic accept;
  logic mul_done;

  assign in_ready_o  = (state_q == RUN);
  assign done_o      = (state_q == DONE);
  assign out_valid_o = out_valid_q;
  assign out_o       = out_q;
  assign accept      = in_valid_i && in_ready_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      gf_q   <= '0;
      am_q   <= '0;
      last_q <= 1'b0;
    end else if (accept) begin
      gf_q   <= gatefn_i;
      am_q   <= addmul_i;
      last_q <= in_last_i;
    end
  end

`ifdef COMPUTE_FJ_SHARED_MUL_EN
  localparam int IW = (NPTS > 1) ? $clog2(NPTS) : 1;

  phase_e                       ph_q, ph_d;
  logic [IW-1:0]                idx_q, idx_d;
  logic [NPTS-1:0][F_NBITS-1:0] prod_q;
  fe_t                          m_p;
  logic                         m_rdy, m_en;

  assign m_en = (state_q == MUL) && (ph_q == PH_ISSUE);

  field_multiplier #(.LAT(MUL_LAT)) u_mul (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .en_i    (m_en),
    .a_i     (gf_q[idx_q]),
    .b_i     (am_q[idx_q]),
    .ready_o (m_rdy),
    .prod_o  (m_p)
  );

  // Each point takes ISSUE + (MUL_LAT-1) WAIT + STORE = MUL_LAT+1 cycles
  always_comb begin
    ph_d     = ph_q;
    idx_d    = idx_q;
    mul_done = 1'b0;
    if (state_q != MUL) begin
      ph_d  = PH_ISSUE;
      idx_d = '0;
    end else begin
      case (ph_q)
        PH_ISSUE: ph_d = PH_WAIT;
        PH_WAIT:  if (m_rdy) ph_d = PH_STORE;
        PH_STORE: begin
          ph_d = PH_ISSUE;
          if (idx_q == IW'(NPTS - 1)) begin
            mul_done = 1'b1;
            idx_d    = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        default:  ph_d = PH_ISSUE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ph_q   <= PH_ISSUE;
      idx_q  <= '0;
      prod_q <= '0;
    end else begin
      ph_q  <= ph_d;
      idx_q <= idx_d;
      if ((state_q == MUL) && (ph_q == PH_STORE)) prod_q[idx_q] <= m_p;
    end
  end

  assign prod = prod_q;
`else
  logic            en_pend_q;
  logic            mul_en;
  logic [NPTS-1:0] mul_rdy;

  always_ff @(posedge clk_i) begin
    if (rst_i) en_pend_q <= 1'b0;
    else       en_pend_q <= accept;
  end

  assign mul_en = (state_q == MUL) && en_pend_q;

  for (genvar k = 0; k < NPTS; k++) begin : g_mul
    field_multiplier #(.LAT(MUL_LAT)) u_mul (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .en_i    (mul_en),
      .a_i     (gf_q[k]),
      .b_i     (am_q[k]),
      .ready_o (mul_rdy[k]),
      .prod_o  (prod[k])
    );
  end

  assign mul_done = &mul_rdy;
`endif

  for (genvar k = 0; k < NPTS; k++) begin : g_add
    field_add_mod u_add (
      .a_i   (out_q[k]),
      .b_i   (prod[k]),
      .sum_o (sum[k])
    );
  end

  always_comb begin
    state_d     = state_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    case (state_q)
      IDLE: if (start_i) begin
        state_d = RUN;
        out_d   = '0;
      end
      RUN: begin
        if (start_i) out_d = '0;
        if (accept)  state_d = MUL;
      end
      MUL: if (mul_done) state_d = ACC;
      ACC: begin
        out_d = sum;
        if (last_q) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
        end else begin
          state_d = RUN;
        end
      end
      DONE: if (start_i) begin
        state_d = RUN;
        out_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end
endmodule

// File: tb/tb_pergate_compute_fj_acc.sv
// Directed bench for pergate_compute_fj_acc with p = 2^61-1, NPTS = 3, multiplier latency 2.
// Expected latencies follow COMPUTE_FJ_SHARED_MUL_EN when it is defined for the build.
module tb_pergate_compute_fj_acc;
  localparam int NPTS = 3;
  localparam int LAT  = 2;
`ifdef COMPUTE_FJ_SHARED_MUL_EN
  localparam int TMUL_TOT = NPTS * (LAT + 1);
`else
  localparam int TMUL_TOT = LAT;
`endif
  localparam int EXP_LAT = TMUL_TOT + 2;
  localparam logic [60:0] P = 61'h1FFF_FFFF_FFFF_FFFF;

  typedef logic [NPTS-1:0][60:0] vfe_t;

  typedef struct packed {
    vfe_t gf;
    vfe_t am;
    logic last;
    vfe_t ex;   // running sum expected after this gate
  } vec_t;

  logic clk, rst, start, in_valid, in_ready, in_last, out_valid, done;
  vfe_t gatefn, addmul, out;

  int nchk, nerr, accepts, range_viol;

  pergate_compute_fj_acc #(.NPTS(NPTS), .MUL_LAT(LAT)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_last_i   (in_last),
    .gatefn_i    (gatefn),
    .addmul_i    (addmul),
    .out_valid_o (out_valid),
    .done_o      (done),
    .out_o       (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (!rst && in_valid && in_ready) accepts++;

  always @(negedge clk) begin
    for (int k = 0; k < NPTS; k++) if (out[k] >= P) range_viol++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string name, input vfe_t ex);
    for (int k = 0; k < NPTS; k++) chk($sformatf("%s[%0d]", name, k), 64'(out[k]), 64'(ex[k]));
  endtask

  function automatic vec_t mk(input logic [60:0] g0, g1, g2, a0, a1, a2,
                              input logic l, input logic [60:0] e0, e1, e2);
    vec_t v;
    v.gf = {g2, g1, g0};
    v.am = {a2, a1, a0};
    v.last = l;
    v.ex = {e2, e1, e0};
    return v;
  endfunction

  // Called and returns at a negedge; start pulse lands on one posedge
  task automatic do_start(input string name);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({name, "_in_ready"}, 64'(in_ready), 64'd1);
    chk({name, "_done"}, 64'(done), 64'd0);
    chk_out({name, "_cleared"}, '0);
  endtask

  // Returns the number of negedges from acceptance to in_ready/out_valid, or -1 on timeout
  task automatic send_gate(input vec_t v, output int lat);
    int n;
    gatefn = v.gf; addmul = v.am; in_last = v.last; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    if (!in_ready) begin
      chk("accept_timeout", 64'd0, 64'd1);
      in_valid = 1'b0;
      lat = -1;
      return;
    end
    @(negedge clk);
    in_valid = 1'b0;
    n = 1;
    while (!in_ready && !out_valid && n < 200) begin @(negedge clk); n++; end
    lat = n;
  endtask

  task automatic run_gate(input string name, input vec_t v);
    int lat;
    send_gate(v, lat);
    chk({name, "_latency"}, 64'(lat), 64'(EXP_LAT));
    chk_out({name, "_out"}, v.ex);
    if (v.last) begin
      chk({name, "_out_valid"}, 64'(out_valid), 64'd1);
      chk({name, "_done"}, 64'(done), 64'd1);
      chk({name, "_in_ready_done"}, 64'(in_ready), 64'd0);
      @(negedge clk);
      chk({name, "_out_valid_pulse"}, 64'(out_valid), 64'd0);
      chk({name, "_done_held"}, 64'(done), 64'd1);
      chk_out({name, "_out_held"}, v.ex);
    end else begin
      chk({name, "_in_ready"}, 64'(in_ready), 64'd1);
      chk({name, "_done_low"}, 64'(done), 64'd0);
    end
  endtask

  vec_t vecs[6];

  initial begin
    int n, a0;
    nchk = 0; nerr = 0; accepts = 0; range_viol = 0;
    vecs[0] = mk(2, 3, 4,  5, 6, 7,  1'b1, 10, 18, 28);
    vecs[1] = mk(1, 1, 1,  2, 3, 4,  1'b0, 2, 3, 4);
    vecs[2] = mk(P-1, 1, 2,  2, 1, 1,  1'b1, 0, 4, 6);
    vecs[3] = mk(P-1, 2, 3,  1, 1, 1,  1'b0, P-1, 2, 3);
    vecs[4] = mk(1, P-1, P-1,  1, P-1, 1,  1'b1, 0, 3, 2);
    vecs[5] = mk(P-1, P-2, 5,  P-1, P-1, 0,  1'b1, 1, 2, 0);

    rst = 1'b1; start = 1'b1; in_valid = 1'b1; in_last = 1'b0;
    gatefn = '0; addmul = '0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk_out("rst_out", '0);
    chk("rst_accepts", 64'(accepts), 64'd0);
    start = 1'b0; in_valid = 1'b0; rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", 64'(in_ready), 64'd0);

    begin
      bit need_start;
      need_start = 1'b1;
      for (int i = 0; i < 6; i++) begin
        if (need_start) do_start($sformatf("start_b%0d", i));
        run_gate($sformatf("vec%0d", i), vecs[i]);
        need_start = vecs[i].last;
      end
    end

    // in_valid held high across MUL/ACC: two gates, exactly two acceptances
    do_start("hold_start");
    a0 = accepts;
    gatefn = {61'd3, 61'd2, 61'd1}; addmul = {61'd1, 61'd1, 61'd1}; in_last = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    gatefn = {61'd6, 61'd5, 61'd4}; in_last = 1'b1;
    n = 1;
    while (!out_valid && n < 200) begin @(negedge clk); n++; end
    in_valid = 1'b0;
    chk("hold_latency", 64'(n), 64'(2 * EXP_LAT));
    chk("hold_accepts", 64'(accepts - a0), 64'd2);
    chk_out("hold_out", {61'd9, 61'd7, 61'd5});
    repeat (3) @(negedge clk);
    chk("hold_no_dup", 64'(accepts - a0), 64'd2);

    // reset while a gate is in MUL
    do_start("rstmul_start");
    run_gate("rstmul_g0", mk(2, 3, 4, 5, 6, 7, 1'b0, 10, 18, 28));
    gatefn = {61'd1, 61'd1, 61'd1}; addmul = {61'd1, 61'd1, 61'd1}; in_last = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("rstmul_in_ready", 64'(in_ready), 64'd0);
    chk("rstmul_done", 64'(done), 64'd0);
    chk("rstmul_out_valid", 64'(out_valid), 64'd0);
    chk_out("rstmul_out", '0);
    rst = 1'b0;
    @(negedge clk);
    chk("rstmul_idle", 64'(in_ready), 64'd0);
    do_start("rstmul_restart");
    run_gate("rstmul_clean", vecs[0]);

    // start in RUN re-clears, start in MUL ignored, start in DONE clears
    do_start("st_start");
    run_gate("st_g0", mk(1, 1, 1, 1, 1, 1, 1'b0, 1, 1, 1));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk_out("st_run_clear", '0);
    chk("st_run_ready", 64'(in_ready), 64'd1);
    gatefn = {61'd2, 61'd2, 61'd2}; addmul = {61'd1, 61'd1, 61'd1}; in_last = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 2;
    while (!out_valid && n < 200) begin @(negedge clk); n++; end
    chk("st_mul_latency", 64'(n), 64'(EXP_LAT));
    chk_out("st_mul_ignored", {61'd2, 61'd2, 61'd2});
    chk("st_mul_done", 64'(done), 64'd1);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk_out("st_done_clear", '0);
    chk("st_done_cleared", 64'(done), 64'd0);
    chk("st_done_ready", 64'(in_ready), 64'd1);

    chk("out_below_p", 64'(range_viol), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
